// File: rtl/unary_nxor_packet_checker_if.sv
// Stream-in / result-out bundle for unary_nxor_packet_checker.
// slave = checker side, master = producer/consumer environment side.
interface unary_nxor_packet_checker_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [N-1:0]     s_data;
  logic             s_last;
  logic             s_exp;
  logic             m_valid;
  logic             m_ready;
  logic             m_parity;
  logic             m_error;
  logic [CNT_W-1:0] m_count;

  modport master (
    output s_valid, s_data, s_last, s_exp, m_ready,
    input  s_ready, m_valid, m_parity, m_error, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, s_exp, m_ready,
    output s_ready, m_valid, m_parity, m_error, m_count
  );
endinterface

// File: rtl/unary_nxor_packet_checker.sv
// Packet-level XNOR parity checker over a valid/ready word stream.
// Optional sticky error flag enabled by defining UNARY_NXOR_STICKY_ERR_EN.
module unary_nxor_packet_checker #(
  parameter string       MODEL = "Structural",
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  unary_nxor_packet_checker_if.slave    bus,
  input  logic                          clr,
  output logic                          err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_parity_q, m_parity_d;
  logic             m_error_q, m_error_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;

  logic [N-1:0]     data;
  logic             nx;
  logic             s_ready_c;
  logic             accept_c;
  logic             load_c;
  logic             acc_next_c;
  logic [CNT_W-1:0] cnt_inc_c;

  assign data = bus.s_data;

  // Per-word XNOR reduction; all three models are functionally identical.
  generate
    if (MODEL == "Behavioral") begin : g_beh
      always_comb begin
        logic p;
        p = 1'b0;
        for (int i = 0; i < int'(N); i++) p = p ^ data[i];
        nx = ~p;
      end
    end else if (MODEL == "DataFlow") begin : g_df
      assign nx = ~^data;
    end else begin : g_struct
      logic [N-1:0] x_chain;
      assign x_chain[0] = data[0];
      for (genvar i = 1; i < int'(N); i++) begin : g_xor
        xor u_xor (x_chain[i], x_chain[i-1], data[i]);
      end
      not u_not (nx, x_chain[N-1]);
    end
  endgenerate

  // Ready only depends on the output slot being free or draining this cycle.
  assign s_ready_c  = !m_valid_q || bus.m_ready;
  assign accept_c   = bus.s_valid && s_ready_c;
  assign load_c     = accept_c && bus.s_last;
  assign acc_next_c = acc_q ^ ~nx;
  assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_parity_q <= 1'b0;
      m_error_q  <= 1'b0;
      m_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_parity_q <= m_parity_d;
      m_error_q  <= m_error_d;
      m_count_q  <= m_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_parity_d = m_parity_q;
    m_error_d  = m_error_q;
    m_count_d  = m_count_q;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    if (load_c) begin
      m_valid_d  = 1'b1;
      m_parity_d = ~acc_next_c;
      m_error_d  = (~acc_next_c) != bus.s_exp;
      m_count_d  = cnt_inc_c;
    end

    // IDLE holds acc=0/cnt=0, so the same update expressions cover both states.
    case (state_q)
      IDLE: begin
        if (accept_c && !bus.s_last) begin
          state_d = ACCUM;
          acc_d   = acc_next_c;
          cnt_d   = cnt_inc_c;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          if (bus.s_last) begin
            state_d = IDLE;
            acc_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            acc_d   = acc_next_c;
            cnt_d   = cnt_inc_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_parity = m_parity_q;
  assign bus.m_error  = m_error_q;
  assign bus.m_count  = m_count_q;

`ifdef UNARY_NXOR_STICKY_ERR_EN
  logic err_q, err_d;

  // A new error load takes priority over a clear on the same edge.
  always_comb begin
    err_d = err_q;
    if (load_c && m_error_d) err_d = 1'b1;
    else if (clr)            err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_unary_nxor_packet_checker.sv
// Directed table-driven bench for unary_nxor_packet_checker (N=8, CNT_W=4).
module tb_unary_nxor_packet_checker;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;
`ifdef UNARY_NXOR_STICKY_ERR_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clr;
  logic err_sticky;

  unary_nxor_packet_checker_if #(.N(N), .CNT_W(CNT_W)) bus ();

  unary_nxor_packet_checker #(.MODEL("Structural"), .N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [7:0] d;
    bit       l;
    bit       e;
    bit       mr;
    bit       x_srdy;
    bit       x_mv;
    bit       x_par;
    bit       x_err;
    bit [3:0] x_cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit v, bit [7:0] d, bit l, bit e, bit mr,
                              bit srdy, bit mv, bit par, bit err, bit [3:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.e = e; t.mr = mr;
    t.x_srdy = srdy; t.x_mv = mv; t.x_par = par; t.x_err = err; t.x_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit [7:0] d, input bit l, input bit e, input bit mr);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_exp   = e;
    bus.m_ready = mr;
  endtask

  // Clock one edge, then compare the registered result a little after it.
  task automatic step_chk(input string name, input bit mv, input bit par, input bit err,
                          input bit [3:0] cnt);
    @(posedge clk);
    #1;
    chk({name, ".m_valid"}, int'(bus.m_valid), int'(mv));
    if (mv) begin
      chk({name, ".m_parity"}, int'(bus.m_parity), int'(par));
      chk({name, ".m_error"},  int'(bus.m_error),  int'(err));
      chk({name, ".m_count"},  int'(bus.m_count),  int'(cnt));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(0, 8'h00, 0, 0, 0);

    // Test plan 1-3 plus idle/ignored-input and hold rows.
    tbl.push_back(mk(1, 8'hFF, 1, 1, 1,  1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'h01, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h07, 1, 1, 1,  1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 1,  1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 8'h03, 1, 1, 0,  0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 8'h03, 1, 1, 0,  0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 8'h03, 1, 1, 0,  0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 8'h03, 1, 1, 0,  0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 8'h03, 1, 1, 1,  1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'h80, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h81, 0, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 1, 0, 1,  1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 0, 0));

    #3;
    chk("rst.m_valid",    int'(bus.m_valid),  0);
    chk("rst.m_parity",   int'(bus.m_parity), 0);
    chk("rst.m_error",    int'(bus.m_error),  0);
    chk("rst.m_count",    int'(bus.m_count),  0);
    chk("rst.err_sticky", int'(err_sticky),   0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e, tbl[i].mr);
      #1;
      chk($sformatf("vec%0d.s_ready", i), int'(bus.s_ready), int'(tbl[i].x_srdy));
      step_chk($sformatf("vec%0d", i), tbl[i].x_mv, tbl[i].x_par, tbl[i].x_err, tbl[i].x_cnt);
    end

    // Saturated packet with an odd beat after saturation: parity must still track.
    for (int i = 0; i < 20; i++) begin
      drive(1, (i == 16) ? 8'h01 : 8'h00, i == 19, 0, 1);
      @(posedge clk);
      #1;
    end
    chk("sat_odd.m_valid",  int'(bus.m_valid),  1);
    chk("sat_odd.m_parity", int'(bus.m_parity), 0);
    chk("sat_odd.m_error",  int'(bus.m_error),  0);
    chk("sat_odd.m_count",  int'(bus.m_count),  15);

    // 20 zero beats then a back-to-back single-beat packet.
    for (int i = 0; i < 19; i++) begin
      drive(1, 8'h00, 0, 1, 1);
      @(posedge clk);
      #1;
    end
    drive(1, 8'h00, 1, 1, 1);
    step_chk("sat20", 1, 1, 0, 15);
    drive(1, 8'h01, 1, 0, 1);
    step_chk("b2b1", 1, 0, 0, 1);

    // Reset in the middle of a two-beat partial packet.
    drive(1, 8'h01, 0, 0, 1);
    step_chk("part1", 0, 0, 0, 0);
    drive(1, 8'h01, 0, 0, 1);
    step_chk("part2", 0, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.m_valid",    int'(bus.m_valid),  0);
    chk("midrst.m_parity",   int'(bus.m_parity), 0);
    chk("midrst.m_error",    int'(bus.m_error),  0);
    chk("midrst.m_count",    int'(bus.m_count),  0);
    chk("midrst.err_sticky", int'(err_sticky),   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 8'h00, 1, 1, 1);
    #1;
    chk("postrst.s_ready", int'(bus.s_ready), 1);
    step_chk("postrst", 1, 1, 0, 1);

    // Sticky error: set, hold through good packet, clear, set-wins-over-clear.
    drive(1, 8'h01, 1, 1, 1);
    step_chk("stk_err", 1, 0, 1, 1);
    chk("stk_err.err_sticky", int'(err_sticky), int'(STK));
    drive(1, 8'h00, 1, 1, 1);
    step_chk("stk_good", 1, 1, 0, 1);
    chk("stk_good.err_sticky", int'(err_sticky), int'(STK));
    drive(0, 8'h00, 0, 0, 1);
    clr = 1'b1;
    step_chk("stk_clr", 0, 0, 0, 0);
    chk("stk_clr.err_sticky", int'(err_sticky), 0);
    drive(1, 8'h01, 1, 1, 1);
    step_chk("stk_setwin", 1, 0, 1, 1);
    chk("stk_setwin.err_sticky", int'(err_sticky), int'(STK));
    drive(0, 8'h00, 0, 0, 1);
    step_chk("stk_clr2", 0, 0, 0, 0);
    chk("stk_clr2.err_sticky", int'(err_sticky), 0);
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
